// File: rtl/mem_pkg.sv
// Shared memory constants for the DCCM and a byte-lane merge helper.
package mem_pkg;

  localparam int unsigned DCCM_WORDS      = 256;
  localparam int unsigned DCCM_ADDR_WIDTH = 8;
  localparam int unsigned DCCM_DATA_WIDTH = 32;
  localparam int unsigned BYTE_LANES      = DCCM_DATA_WIDTH / 8;

  // Lanes with we[i]=1 take new_word, the rest keep old_word.
  function automatic logic [DCCM_DATA_WIDTH-1:0] merge_bytes(
    input logic [BYTE_LANES-1:0]      we,
    input logic [DCCM_DATA_WIDTH-1:0] new_word,
    input logic [DCCM_DATA_WIDTH-1:0] old_word
  );
    logic [DCCM_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(BYTE_LANES); i++) begin
      if (we[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dff_ram_if.sv
// Memory-side bus of the flip-flop RAM: access request in, registered read data out.
interface dff_ram_if;
  import mem_pkg::*;

  logic                       EN;
  logic [BYTE_LANES-1:0]      WE;
  logic [DCCM_ADDR_WIDTH-1:0] A;
  logic [DCCM_DATA_WIDTH-1:0] Di;
  logic [DCCM_DATA_WIDTH-1:0] Do;

  modport master (output EN, output WE, output A, output Di, input Do);
  modport slave  (input EN, input WE, input A, input Di, output Do);

endinterface

// File: rtl/dff_ram_word.sv
// One storage word with per-byte write enables; deliberately not reset.
module dff_ram_word
  import mem_pkg::*;
(
  input  logic                       clk,
  input  logic [BYTE_LANES-1:0]      be,
  input  logic [DCCM_DATA_WIDTH-1:0] d,
  output logic [DCCM_DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(BYTE_LANES); i++) begin
      if (be[i]) q[8*i +: 8] <= d[8*i +: 8];
    end
  end

endmodule

// File: rtl/dff_ram.sv
// 256 x 32 flip-flop RAM with byte write enables and a write-first registered read port.
module dff_ram
  import mem_pkg::*;
#(
  parameter int unsigned WORDS      = DCCM_WORDS,
  parameter int unsigned ADDR_WIDTH = DCCM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DCCM_DATA_WIDTH
) (
  input logic       CLK,
  input logic       RST_N,
  dff_ram_if.slave  bus
);

  logic [DATA_WIDTH-1:0] word_q [WORDS];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] do_q;

  for (genvar w = 0; w < int'(WORDS); w++) begin : g_word
    logic [BYTE_LANES-1:0] wr_be;

    // The address term is zero for unselected words, so an unknown EN/WE only reaches mem[A].
    assign wr_be = {BYTE_LANES{bus.EN && (bus.A == ADDR_WIDTH'(w))}} & bus.WE;

    dff_ram_word u_word (
      .clk (CLK),
      .be  (wr_be),
      .d   (bus.Di),
      .q   (word_q[w])
    );
  end

  always_comb begin
    rd_word = word_q[bus.A];
    merged  = merge_bytes(bus.WE, bus.Di, rd_word);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      do_q <= '0;
    end else if (bus.EN) begin
      do_q <= merged;
    end
  end

  assign bus.Do = do_q;

endmodule

// File: tb/tb_dff_ram.sv
// Directed self-checking bench for dff_ram with hand-computed expected read data.
module tb_dff_ram;
  import mem_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  dff_ram_if bus ();

  dff_ram dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one request on the falling edge, then sample just after the rising edge.
  task automatic access(input logic en, input logic [3:0] we, input logic [7:0] a,
                        input logic [31:0] di);
    @(negedge clk);
    bus.EN = en;
    bus.WE = we;
    bus.A  = a;
    bus.Di = di;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    bus.EN   = 1'b1;
    bus.WE   = 4'hF;
    bus.A    = 8'h05;
    bus.Di   = 32'hDEADBEEF;

    // Reset held while enabled writes are presented: Do must stay cleared.
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_hold", bus.Do, 32'h0);
    @(posedge clk);
    #1;
    check_eq("reset_hold2", bus.Do, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Full-word write is visible immediately (write-first), then read back.
    access(1'b1, 4'hF, 8'h05, 32'h12345678);
    check_eq("wr05_first", bus.Do, 32'h12345678);
    access(1'b1, 4'h0, 8'h05, 32'h0);
    check_eq("rd05", bus.Do, 32'h12345678);

    // Partial write merges lanes 0 and 2 into the old word.
    access(1'b1, 4'b0101, 8'h05, 32'hAABBCCDD);
    check_eq("wr05_lanes", bus.Do, 32'h12BB56DD);
    access(1'b1, 4'h0, 8'h05, 32'hFFFFFFFF);
    check_eq("rd05_lanes", bus.Do, 32'h12BB56DD);

    // Address boundaries, with a middle word that must stay untouched.
    access(1'b1, 4'hF, 8'h7F, 32'hCAFEF00D);
    access(1'b1, 4'hF, 8'h00, 32'h00000001);
    check_eq("wr00", bus.Do, 32'h00000001);
    access(1'b1, 4'hF, 8'hFF, 32'h80000000);
    check_eq("wrFF", bus.Do, 32'h80000000);
    access(1'b1, 4'h0, 8'h00, 32'h0);
    check_eq("rd00", bus.Do, 32'h00000001);
    access(1'b1, 4'h0, 8'hFF, 32'h0);
    check_eq("rdFF", bus.Do, 32'h80000000);
    access(1'b1, 4'h0, 8'h7F, 32'h0);
    check_eq("rd7F", bus.Do, 32'hCAFEF00D);

    // Top lane only on the last word.
    access(1'b1, 4'b1000, 8'hFF, 32'hAB123456);
    check_eq("wrFF_lane3", bus.Do, 32'hAB000000);
    access(1'b1, 4'h0, 8'h7F, 32'h0);
    check_eq("rd7F_again", bus.Do, 32'hCAFEF00D);

    // Disabled cycles neither write nor move Do.
    access(1'b0, 4'hF, 8'h05, 32'hFFFFFFFF);
    check_eq("en0_hold", bus.Do, 32'hCAFEF00D);
    access(1'b0, 4'h0, 8'h00, 32'h0);
    check_eq("en0_hold2", bus.Do, 32'hCAFEF00D);
    access(1'b1, 4'h0, 8'h05, 32'h0);
    check_eq("rd05_after_en0", bus.Do, 32'h12BB56DD);

    // Back-to-back alternating writes and reads.
    access(1'b1, 4'hF, 8'h10, 32'h11111111);
    check_eq("b2b_wr10", bus.Do, 32'h11111111);
    access(1'b1, 4'h0, 8'h10, 32'h0);
    check_eq("b2b_rd10", bus.Do, 32'h11111111);
    access(1'b1, 4'hF, 8'h11, 32'h22222222);
    check_eq("b2b_wr11", bus.Do, 32'h22222222);
    access(1'b1, 4'h0, 8'h11, 32'h0);
    check_eq("b2b_rd11", bus.Do, 32'h22222222);
    access(1'b1, 4'hF, 8'h10, 32'h33333333);
    access(1'b1, 4'h0, 8'h10, 32'h0);
    check_eq("b2b_rd10_new", bus.Do, 32'h33333333);
    access(1'b1, 4'h0, 8'h11, 32'h0);
    check_eq("b2b_rd11_keep", bus.Do, 32'h22222222);

    // Asynchronous clear mid-cycle, then the array is still intact.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_clear", bus.Do, 32'h0);
    @(negedge clk);
    bus.EN = 1'b0;
    rst_n  = 1'b1;
    access(1'b1, 4'h0, 8'h05, 32'h0);
    check_eq("rd05_after_rst", bus.Do, 32'h12BB56DD);
    access(1'b1, 4'h0, 8'hFF, 32'h0);
    check_eq("rdFF_after_rst", bus.Do, 32'hAB000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
